// File: rtl/fulladder_bist.sv
// fulladder_bist: exhaustive self-test engine for a single-bit full adder.
// Walks {a,b,cin} through 000..111 and holds each vector SETTLE_CYCLES
// cycles. At the end of each hold it compares {cout,sum} with a+b+cin.
// It accumulates a mismatch count and remembers the first failing vector.
module fulladder_bist #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_cin,
  input  logic       dut_sum,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_fail_vld,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The last settle-counter value of a hold; the response is sampled there.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_r, state_s;
  logic [2:0] vec_r, vec_s;
  logic [3:0] settle_r, settle_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       pass_r, pass_s;
  logic [3:0] err_r, err_s;
  logic       ffv_r, ffv_s;
  logic [2:0] ffvec_r, ffvec_s;
  logic [1:0] expect_s;
  logic       mismatch_s;

  // Arithmetic reference: {cout,sum} of a full adder is the 2-bit sum a+b+cin.
  function automatic logic [1:0] fa_expect(input logic [2:0] v);
    fa_expect = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  assign expect_s   = fa_expect(vec_r);
  assign mismatch_s = ({dut_cout, dut_sum} != expect_s);

  // The stimulus comes straight from the vector register, so it is registered.
  assign {dut_a, dut_b, dut_cin} = vec_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_r;
  assign first_fail_vld = ffv_r;
  assign first_fail_vec = ffvec_r;

  // Next-state and result logic; every register holds unless a rule below changes it.
  always_comb begin
    state_s  = state_r;
    vec_s    = vec_r;
    settle_s = settle_r;
    busy_s   = busy_r;
    done_s   = done_r;
    pass_s   = pass_r;
    err_s    = err_r;
    ffv_s    = ffv_r;
    ffvec_s  = ffvec_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s  = RUN;
          vec_s    = 3'd0;
          settle_s = 4'd0;
          err_s    = 4'd0;
          ffv_s    = 1'b0;
          ffvec_s  = 3'd0;
          done_s   = 1'b0;
          pass_s   = 1'b0;
          busy_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (settle_r == SETTLE_LAST) begin
          // Eight vectors at most, so the 4-bit count cannot overflow.
          err_s = err_r + {3'b000, mismatch_s};
          if (mismatch_s && !ffv_r) begin
            ffv_s   = 1'b1;
            ffvec_s = vec_r;
          end else begin
            ffv_s   = ffv_r;
            ffvec_s = ffvec_r;
          end
          if (vec_r != 3'd7) begin
            vec_s    = vec_r + 3'd1;
            settle_s = 4'd0;
          end else begin
            // The last vector stays on the stimulus while results are held.
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_s == 4'd0);
          end
        end else begin
          settle_s = settle_r + 4'd1;
        end
      end
      default: begin
        // Illegal encoding: fall back to a quiet idle.
        state_s  = IDLE;
        vec_s    = 3'd0;
        settle_s = 4'd0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        pass_s   = 1'b0;
        err_s    = 4'd0;
        ffv_s    = 1'b0;
        ffvec_s  = 3'd0;
      end
    endcase
  end

  // State and result registers; a reset aborts any run and clears every result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      vec_r    <= 3'd0;
      settle_r <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      err_r    <= 4'd0;
      ffv_r    <= 1'b0;
      ffvec_r  <= 3'd0;
    end else begin
      state_r  <= state_s;
      vec_r    <= vec_s;
      settle_r <= settle_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      pass_r   <= pass_s;
      err_r    <= err_s;
      ffv_r    <= ffv_s;
      ffvec_r  <= ffvec_s;
    end
  end

endmodule
